// File: rtl/rev_mux_n_pipe.sv
// rev_mux_n_pipe: 2-stage valid/ready reversible N-way mux (x_out = x_in ^ data[sel], inputs passed through) with net op counter and sticky under/overflow flags
module rev_mux_n_pipe #(
  parameter int W = 12,
  parameter int N = 2,
  parameter int SEL_W = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             dir_in,
  input  logic [SEL_W-1:0] sel_in,
  input  logic [N*W-1:0]   data_in,
  input  logic [W-1:0]     x_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             dir_out,
  output logic [SEL_W-1:0] sel_out,
  output logic [N*W-1:0]   data_out,
  output logic [W-1:0]     x_out,
  output logic             sel_err,
  output logic [CNT_W-1:0] op_count,
  output logic             underflow,
  output logic             overflow
);
  localparam logic [SEL_W:0] NL = (SEL_W+1)'(N);
  logic             s1_valid, s1_dir, s1_err, ld1, ld2, xfer, err;
  logic [SEL_W-1:0] s1_sel;
  logic [N*W-1:0]   s1_data;
  logic [W-1:0]     s1_x, mux;
  logic [N-1:0]     s1_oh, oh;
  assign ld2 = !out_valid | out_ready;
  assign ld1 = !s1_valid | ld2;
  assign in_ready = !rst & ld1;
  assign xfer = out_valid & out_ready & !sel_err;
  assign err = {1'b0, sel_in} >= NL;
  always_comb begin
    oh = '0;
    for (int k = 0; k < N; k++) oh[k] = sel_in == SEL_W'(k);
  end
  always_comb begin
    mux = '0;
    for (int k = 0; k < N; k++) mux = mux | ({W{s1_oh[k]}} & s1_data[k*W +: W]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_dir   <= 1'b0;
      s1_sel   <= '0;
      s1_data  <= '0;
      s1_x     <= '0;
      s1_oh    <= '0;
      s1_err   <= 1'b0;
    end else if (ld1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_dir  <= dir_in;
        s1_sel  <= sel_in;
        s1_data <= data_in;
        s1_x    <= x_in;
        s1_oh   <= oh;
        s1_err  <= err;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      dir_out   <= 1'b0;
      sel_out   <= '0;
      data_out  <= '0;
      x_out     <= '0;
      sel_err   <= 1'b0;
    end else if (ld2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        dir_out  <= s1_dir;
        sel_out  <= s1_sel;
        data_out <= s1_data;
        x_out    <= s1_x ^ mux;
        sel_err  <= s1_err;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count  <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else if (xfer) begin
      if (!dir_out) begin
        if (&op_count) overflow <= 1'b1;
        else op_count <= op_count + CNT_W'(1);
      end else begin
        if (op_count == '0) underflow <= 1'b1;
        else op_count <= op_count - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_rev_mux_n_pipe.sv
// tb_rev_mux_n_pipe: vector table, stall/reset sequences and a randomized scoreboard for rev_mux_n_pipe
module tb_rev_mux_n_pipe;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic a_in_valid = 0, a_in_ready, a_dir = 0, a_out_valid, a_out_ready = 1, a_dir_out, a_sel_err, a_unf, a_ovf;
  logic [0:0] a_sel = 0, a_sel_out;
  logic [23:0] a_data = 0, a_data_out;
  logic [11:0] a_x = 0, a_x_out;
  logic [7:0] a_cnt;
  logic b_in_valid = 0, b_in_ready, b_dir = 0, b_out_valid, b_out_ready = 1, b_dir_out, b_sel_err, b_unf, b_ovf;
  logic [1:0] b_sel = 0, b_sel_out, b_cnt;
  logic [35:0] b_data = 0, b_data_out;
  logic [11:0] b_x = 0, b_x_out;
  rev_mux_n_pipe dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .dir_in(a_dir),
    .sel_in(a_sel), .data_in(a_data), .x_in(a_x), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .dir_out(a_dir_out), .sel_out(a_sel_out), .data_out(a_data_out), .x_out(a_x_out),
    .sel_err(a_sel_err), .op_count(a_cnt), .underflow(a_unf), .overflow(a_ovf));
  rev_mux_n_pipe #(.W(12), .N(3), .SEL_W(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .dir_in(b_dir),
    .sel_in(b_sel), .data_in(b_data), .x_in(b_x), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .dir_out(b_dir_out), .sel_out(b_sel_out), .data_out(b_data_out), .x_out(b_x_out),
    .sel_err(b_sel_err), .op_count(b_cnt), .underflow(b_unf), .overflow(b_ovf));
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  typedef struct {logic dir; logic sel; logic [11:0] d0, d1, x, ex; logic [7:0] ecnt; logic eunf;} vec_t;
  vec_t tv[8];
  typedef struct {logic [11:0] x; logic err; logic dir; logic [1:0] sel; logic [35:0] data;} exp_t;
  exp_t q[$];
  int mcnt = 0;
  logic movf = 0, munf = 0, last_err = 0;
  logic [11:0] last_x = 0;
  task automatic b_cycle(input logic v, input logic d, input logic [1:0] s, input logic [11:0] x,
                         input logic [35:0] dat, input logic r);
    exp_t e, h;
    @(negedge clk);
    b_in_valid = v; b_dir = d; b_sel = s; b_x = x; b_data = dat; b_out_ready = r;
    #1;
    if (b_out_valid && b_out_ready) begin
      if (q.size() == 0) chk("b_extra_beat", 1, 0);
      else begin
        h = q.pop_front();
        chk("b_x_out", b_x_out, h.x);
        chk("b_sel_err", b_sel_err, h.err);
        chk("b_data_out", b_data_out, h.data);
        chk("b_sel_out", b_sel_out, h.sel);
        chk("b_dir_out", b_dir_out, h.dir);
        last_x = b_x_out; last_err = b_sel_err;
        if (!h.err) begin
          if (!h.dir) begin if (mcnt == 3) movf = 1; else mcnt++; end
          else begin if (mcnt == 0) munf = 1; else mcnt--; end
        end
      end
    end
    if (b_in_valid && b_in_ready) begin
      e.err = s > 2;
      e.x = e.err ? x : x ^ dat[s*12 +: 12];
      e.dir = d; e.sel = s; e.data = dat;
      q.push_back(e);
    end
    @(posedge clk); #1;
    chk("b_op_count", b_cnt, mcnt);
    chk("b_overflow", b_ovf, movf);
    chk("b_underflow", b_unf, munf);
  endtask
  int n, sent, recv;
  logic held, saw_block, stale;
  logic [11:0] held_x, sx[8];
  initial begin
    tv[0] = '{0, 0, 12'd15,  12'd255,  12'h000, 12'd15,  8'd1, 0};
    tv[1] = '{1, 0, 12'd15,  12'd255,  12'd15,  12'h000, 8'd0, 0};
    tv[2] = '{0, 1, 12'd15,  12'd255,  12'h000, 12'd255, 8'd1, 0};
    tv[3] = '{1, 1, 12'd15,  12'd255,  12'd255, 12'h000, 8'd0, 0};
    tv[4] = '{1, 1, 12'd15,  12'd255,  12'h000, 12'd255, 8'd0, 1};
    tv[5] = '{0, 0, 12'hA5A, 12'h3C3,  12'hFFF, 12'h5A5, 8'd1, 1};
    tv[6] = '{0, 1, 12'hA5A, 12'h3C3,  12'h123, 12'h2E0, 8'd2, 1};
    tv[7] = '{1, 1, 12'hA5A, 12'h3C3,  12'h2E0, 12'h123, 8'd1, 1};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", a_in_ready, 0);
    rst = 0;
    #1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_op_count", a_cnt, 0);
    chk("rst_x_out", a_x_out, 0);
    chk("rst_flags", {a_unf, a_ovf, a_sel_err}, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a_dir = tv[i].dir; a_sel = tv[i].sel; a_data = {tv[i].d1, tv[i].d0}; a_x = tv[i].x;
      a_in_valid = 1; a_out_ready = 1;
      #1;
      chk("tab_in_ready", a_in_ready, 1);
      @(posedge clk); #1;
      a_in_valid = 0;
      n = 0;
      do begin @(negedge clk); n++; end while (!a_out_valid && n < 5);
      chk("tab_latency", n, 2);
      chk("tab_x_out", a_x_out, tv[i].ex);
      chk("tab_data_out", a_data_out, {tv[i].d1, tv[i].d0});
      chk("tab_sel_dir", {a_sel_out, a_dir_out, a_sel_err}, {tv[i].sel, tv[i].dir, 1'b0});
      @(posedge clk); #1;
      chk("tab_op_count", a_cnt, tv[i].ecnt);
      chk("tab_underflow", a_unf, tv[i].eunf);
    end
    for (int i = 0; i < 8; i++) sx[i] = 12'(i * 273) ^ (i[0] ? 12'h0F0 : 12'h00F);
    sent = 0; recv = 0; held = 0; saw_block = 0; held_x = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      a_out_ready = !(c >= 3 && c <= 6);
      a_in_valid = sent < 8;
      a_sel = sent[0]; a_x = 12'(sent * 273); a_dir = 0; a_data = {12'h0F0, 12'h00F};
      #1;
      if (a_out_valid && !a_out_ready) begin
        if (held) chk("stall_hold", a_x_out, held_x);
        held = 1; held_x = a_x_out;
      end else held = 0;
      if (!a_in_ready) saw_block = 1;
      if (a_out_valid && a_out_ready) begin
        if (recv < 8) chk("stream_x", a_x_out, sx[recv]);
        recv++;
      end
      if (a_in_valid && a_in_ready) sent++;
      @(posedge clk);
    end
    chk("stream_count", recv, 8);
    chk("stream_backpressure", saw_block, 1);
    #1;
    chk("stream_op_count", a_cnt, 9);
    @(negedge clk);
    a_out_ready = 0; a_in_valid = 1; a_x = 12'h777; a_sel = 0; a_dir = 0;
    @(negedge clk);
    @(negedge clk);
    a_in_valid = 0; rst = 1;
    #1;
    chk("rst_in_ready_mid", a_in_ready, 0);
    @(posedge clk); #1;
    rst = 0;
    chk("rst2_out_valid", a_out_valid, 0);
    chk("rst2_op_count", a_cnt, 0);
    chk("rst2_flags", {a_unf, a_ovf}, 0);
    chk("rst2_x_out", a_x_out, 0);
    chk("rst2_data_out", a_data_out, 0);
    a_out_ready = 1; stale = 0;
    repeat (6) begin @(negedge clk); if (a_out_valid) stale = 1; end
    chk("rst2_no_stale", stale, 0);
    for (int i = 0; i < 4; i++) b_cycle(1, 0, 2'd0, 12'h000, 36'h003_002_001, 1);
    repeat (3) b_cycle(0, 0, 2'd0, 12'h000, 36'h0, 1);
    chk("b_sat_count", b_cnt, 3);
    chk("b_sat_overflow", b_ovf, 1);
    b_cycle(1, 0, 2'd3, 12'hABC, 36'h123_456_789, 1);
    repeat (3) b_cycle(0, 0, 2'd0, 12'h000, 36'h0, 1);
    chk("b_oor_x", last_x, 12'hABC);
    chk("b_oor_err", last_err, 1);
    chk("b_oor_count", b_cnt, 3);
    repeat (1500) b_cycle($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), 12'($urandom),
                          36'({$urandom, $urandom}), $urandom_range(0, 3) != 0);
    repeat (6) b_cycle(0, 0, 2'd0, 12'h000, 36'h0, 1);
    chk("b_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
